// File: rtl/sort_sched.sv
// Round-robin scheduler sharing the A* open-list sort engine between insert and pop-min requesters.
// Optional watchdog on the engine handshake is enabled by defining SORT_SCHED_WDOG_EN.
module sort_sched #(
    parameter int KEY_W = 16,
    parameter int ID_W  = 10,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
`ifdef SORT_SCHED_WDOG_EN
    ,
    parameter int WDOG_CYC = 255
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Ins_Req,
    input  logic [KEY_W-1:0] Ins_Key,
    input  logic [ID_W-1:0]  Ins_Id,
    output logic             Ins_Ack,
    input  logic             Pop_Req,
    output logic             Pop_Ack,
    output logic             Pop_Empty,
    output logic [KEY_W-1:0] Pop_Key,
    output logic [ID_W-1:0]  Pop_Id,
    input  logic             Flush,
    output logic             Full,
    output logic [CNT_W-1:0] Count,
    output logic             Srt_Start,
    output logic [1:0]       Srt_Op,
    output logic [KEY_W-1:0] Srt_Key,
    output logic [ID_W-1:0]  Srt_Id,
    input  logic             Srt_Done,
    input  logic [KEY_W-1:0] Srt_Key_Out,
    input  logic [ID_W-1:0]  Srt_Id_Out,
    output logic             Err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_POP = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    state_t            state, state_n;
    logic              last_pop, last_pop_n;
    logic [1:0]        op_n;
    logic [KEY_W-1:0]  key_n, pop_key_n;
    logic [ID_W-1:0]   id_n, pop_id_n;
    logic [CNT_W-1:0]  count_n;
    logic              start_n, ins_ack_n, pop_ack_n, empty_n, finish;
    logic              ins_ok, grant_pop;

`ifdef SORT_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog, wdog_n;
    logic            err_n;
`endif

    // last_pop points at the requester served most recently; reset favours insert
    assign ins_ok    = Ins_Req && !Full;
    assign grant_pop = Pop_Req && (!ins_ok || !last_pop);

    always_comb begin
        state_n    = state;
        last_pop_n = last_pop;
        op_n       = Srt_Op;
        key_n      = Srt_Key;
        id_n       = Srt_Id;
        count_n    = Count;
        pop_key_n  = Pop_Key;
        pop_id_n   = Pop_Id;
        start_n    = 1'b0;
        ins_ack_n  = 1'b0;
        pop_ack_n  = 1'b0;
        empty_n    = 1'b0;
        finish     = 1'b0;
`ifdef SORT_SCHED_WDOG_EN
        err_n      = Err;
        wdog_n     = '0;
`endif
        case (state)
            IDLE: begin
                if (Flush) begin
                    op_n    = OP_CLR;
                    key_n   = '0;
                    id_n    = '0;
                    start_n = 1'b1;
                    state_n = ISSUE;
                end else if (grant_pop) begin
                    last_pop_n = 1'b1;
                    op_n       = OP_POP;
                    key_n      = '0;
                    id_n       = '0;
                    if (Count == '0) begin
                        pop_ack_n = 1'b1;
                        empty_n   = 1'b1;
                        state_n   = RESP;
                    end else begin
                        start_n = 1'b1;
                        state_n = ISSUE;
                    end
                end else if (ins_ok) begin
                    last_pop_n = 1'b0;
                    op_n       = OP_INS;
                    key_n      = Ins_Key;
                    id_n       = Ins_Id;
                    start_n    = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (Srt_Done) begin
                    finish  = 1'b1;
                    state_n = RESP;
                    if (Srt_Op == OP_POP) begin
                        pop_key_n = Srt_Key_Out;
                        pop_id_n  = Srt_Id_Out;
                    end
`ifdef SORT_SCHED_WDOG_EN
                end else if (wdog == WD_W'(WDOG_CYC - 1)) begin
                    // Give up on the engine: ack the requester, leave the count alone
                    err_n     = 1'b1;
                    state_n   = RESP;
                    ins_ack_n = (Srt_Op == OP_INS);
                    pop_ack_n = (Srt_Op == OP_POP);
                    empty_n   = (Srt_Op == OP_POP);
                end else begin
                    wdog_n = wdog + 1'b1;
`endif
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (finish) begin
            case (Srt_Op)
                OP_INS: begin
                    ins_ack_n = 1'b1;
                    if (Count != CNT_MAX) count_n = Count + 1'b1;
                end
                OP_POP: begin
                    pop_ack_n = 1'b1;
                    if (Count != '0) count_n = Count - 1'b1;
                end
                OP_CLR:  count_n = '0;
                default: count_n = Count;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            last_pop  <= 1'b1;
            Srt_Op    <= 2'b00;
            Srt_Key   <= '0;
            Srt_Id    <= '0;
            Srt_Start <= 1'b0;
            Count     <= '0;
            Full      <= 1'b0;
            Ins_Ack   <= 1'b0;
            Pop_Ack   <= 1'b0;
            Pop_Empty <= 1'b0;
            Pop_Key   <= '0;
            Pop_Id    <= '0;
        end else begin
            state     <= state_n;
            last_pop  <= last_pop_n;
            Srt_Op    <= op_n;
            Srt_Key   <= key_n;
            Srt_Id    <= id_n;
            Srt_Start <= start_n;
            Count     <= count_n;
            Full      <= (count_n == CNT_MAX);
            Ins_Ack   <= ins_ack_n;
            Pop_Ack   <= pop_ack_n;
            Pop_Empty <= empty_n;
            Pop_Key   <= pop_key_n;
            Pop_Id    <= pop_id_n;
        end
    end

`ifdef SORT_SCHED_WDOG_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wdog <= '0;
            Err  <= 1'b0;
        end else begin
            wdog <= wdog_n;
            Err  <= err_n;
        end
    end
`else
    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_sched.sv
// Directed bench for sort_sched with a behavioural sort engine (Done two cycles after Start).
// Watchdog checks are compiled in when SORT_SCHED_WDOG_EN is defined.
module tb_sort_sched;

    localparam int KEY_W = 16;
    localparam int ID_W  = 10;
    localparam int CNT_W = 7;

    logic             Clk, Reset;
    logic             Ins_Req, Pop_Req, Flush;
    logic [KEY_W-1:0] Ins_Key;
    logic [ID_W-1:0]  Ins_Id;
    logic             Ins_Ack, Pop_Ack, Pop_Empty, Full, Srt_Start, Err;
    logic [KEY_W-1:0] Pop_Key, Srt_Key, Srt_Key_Out;
    logic [ID_W-1:0]  Pop_Id, Srt_Id, Srt_Id_Out;
    logic [CNT_W-1:0] Count;
    logic [1:0]       Srt_Op;
    logic             Srt_Done;

    int tests_run = 0;
    int tests_failed = 0;
    int start_cnt = 0;
    int ins_ack_cnt = 0;

    sort_sched dut (
        .Clk(Clk), .Reset(Reset),
        .Ins_Req(Ins_Req), .Ins_Key(Ins_Key), .Ins_Id(Ins_Id), .Ins_Ack(Ins_Ack),
        .Pop_Req(Pop_Req), .Pop_Ack(Pop_Ack), .Pop_Empty(Pop_Empty),
        .Pop_Key(Pop_Key), .Pop_Id(Pop_Id),
        .Flush(Flush), .Full(Full), .Count(Count),
        .Srt_Start(Srt_Start), .Srt_Op(Srt_Op), .Srt_Key(Srt_Key), .Srt_Id(Srt_Id),
        .Srt_Done(Srt_Done), .Srt_Key_Out(Srt_Key_Out), .Srt_Id_Out(Srt_Id_Out),
        .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Srt_Start) start_cnt <= start_cnt + 1;
        if (Ins_Ack) ins_ack_cnt <= ins_ack_cnt + 1;
    end

    // Engine model: unsorted store, pop returns the minimum key; eng_mute withholds Done
    logic [KEY_W-1:0] eq_key[$];
    logic [ID_W-1:0]  eq_id[$];
    logic             eng_busy, eng_mute;
    logic [1:0]       eng_op;
    logic [KEY_W-1:0] eng_k;
    logic [ID_W-1:0]  eng_i;

    always @(posedge Clk or negedge Reset) begin : engine
        int mi;
        if (!Reset) begin
            eng_busy    <= 1'b0;
            Srt_Done    <= 1'b0;
            Srt_Key_Out <= '0;
            Srt_Id_Out  <= '0;
            eq_key.delete();
            eq_id.delete();
        end else begin
            Srt_Done <= 1'b0;
            if (Srt_Start) begin
                eng_busy <= 1'b1;
                eng_op   <= Srt_Op;
                eng_k    <= Srt_Key;
                eng_i    <= Srt_Id;
            end else if (eng_busy && !eng_mute) begin
                eng_busy <= 1'b0;
                Srt_Done <= 1'b1;
                case (eng_op)
                    2'b00: begin
                        eq_key.push_back(eng_k);
                        eq_id.push_back(eng_i);
                    end
                    2'b01: begin
                        mi = 0;
                        for (int j = 1; j < eq_key.size(); j++)
                            if (eq_key[j] < eq_key[mi]) mi = j;
                        if (eq_key.size() > 0) begin
                            Srt_Key_Out <= eq_key[mi];
                            Srt_Id_Out  <= eq_id[mi];
                            eq_key.delete(mi);
                            eq_id.delete(mi);
                        end
                    end
                    default: begin
                        eq_key.delete();
                        eq_id.delete();
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_insert(input logic [KEY_W-1:0] k, input logic [ID_W-1:0] id, output int lat);
        Ins_Req = 1'b1;
        Ins_Key = k;
        Ins_Id  = id;
        lat = 0;
        while (!Ins_Ack && lat < 50) begin
            step();
            lat++;
        end
        checkOutput("ins_ack", {31'd0, Ins_Ack}, 32'd1);
        Ins_Req = 1'b0;
        step();
    endtask

    task automatic do_pop(output logic [KEY_W-1:0] k, output logic [ID_W-1:0] id,
                          output logic e, output int lat);
        Pop_Req = 1'b1;
        lat = 0;
        while (!Pop_Ack && lat < 400) begin
            step();
            lat++;
        end
        checkOutput("pop_ack", {31'd0, Pop_Ack}, 32'd1);
        k = Pop_Key;
        id = Pop_Id;
        e = Pop_Empty;
        Pop_Req = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin : applyStimulus
        int lat, cyc, n, s0, ns;
        logic [KEY_W-1:0] k;
        logic [ID_W-1:0] id;
        logic e;
        logic [3:0] order;
        logic [KEY_W-1:0] pk[2];
        logic [1:0] ops[4];
        logic [CNT_W-1:0] cnt_at[4];
        logic got_ins, got_pop, pop_first;

        Reset = 1'b0; Ins_Req = 1'b0; Pop_Req = 1'b0; Flush = 1'b0;
        Ins_Key = '0; Ins_Id = '0; eng_mute = 1'b0;
        step(); step();
        checkOutput("rst_count", 32'(Count), 32'd0);
        checkOutput("rst_full", {31'd0, Full}, 32'd0);
        checkOutput("rst_start", {31'd0, Srt_Start}, 32'd0);
        checkOutput("rst_acks", {30'd0, Ins_Ack, Pop_Ack}, 32'd0);
        checkOutput("rst_popkey", 32'(Pop_Key), 32'd0);
        checkOutput("rst_err", {31'd0, Err}, 32'd0);
        Reset = 1'b1;
        step();

        // Empty pop answers directly without touching the engine
        do_pop(k, id, e, lat);
        checkOutput("empty_pop_lat", 32'(lat), 32'd1);
        checkOutput("empty_pop_flag", {31'd0, e}, 32'd1);
        checkOutput("empty_pop_nostart", 32'(start_cnt), 32'd0);

        do_insert(16'd30, 10'd1, lat);
        checkOutput("ins_lat", 32'(lat), 32'd4);
        do_insert(16'd10, 10'd2, lat);
        do_insert(16'd20, 10'd3, lat);
        checkOutput("count_3", 32'(Count), 32'd3);
        do_pop(k, id, e, lat);
        checkOutput("pop_key_10", 32'(k), 32'd10);
        checkOutput("pop_id_2", 32'(id), 32'd2);
        checkOutput("pop_not_empty", {31'd0, e}, 32'd0);
        checkOutput("pop_lat", 32'(lat), 32'd4);
        checkOutput("count_2", 32'(Count), 32'd2);

        // Bring Count to 5 with a pop as the last grant
        do_insert(16'd40, 10'd4, lat);
        do_insert(16'd50, 10'd5, lat);
        do_insert(16'd60, 10'd6, lat);
        do_insert(16'd5, 10'd7, lat);
        do_pop(k, id, e, lat);
        checkOutput("pop_key_5", 32'(k), 32'd5);
        checkOutput("count_5", 32'(Count), 32'd5);

        // Both requesters held: grants must alternate starting with insert
        Ins_Req = 1'b1; Ins_Key = 16'd70; Ins_Id = 10'd8; Pop_Req = 1'b1;
        n = 0; cyc = 0; order = '0;
        while (n < 4 && cyc < 100) begin
            step();
            cyc++;
            if (Ins_Ack) begin
                order[n] = 1'b0;
                n++;
                Ins_Key = 16'd80;
                Ins_Id  = 10'd9;
            end
            if (Pop_Ack) begin
                order[n] = 1'b1;
                pk[n/2] = Pop_Key;
                n++;
            end
        end
        Ins_Req = 1'b0; Pop_Req = 1'b0;
        step();
        checkOutput("rr_grants", 32'(n), 32'd4);
        checkOutput("rr_order", 32'(order), 32'b1010);
        checkOutput("rr_pop0", 32'(pk[0]), 32'd20);
        checkOutput("rr_pop1", 32'(pk[1]), 32'd30);
        checkOutput("rr_count", 32'(Count), 32'd5);

        // Fill to capacity
        for (int i = 0; i < 59; i++)
            do_insert(16'(100 + i), 10'(i), lat);
        checkOutput("fill_count", 32'(Count), 32'd64);
        checkOutput("fill_full", {31'd0, Full}, 32'd1);

        Ins_Req = 1'b1; Ins_Key = 16'd7; Ins_Id = 10'd11;
        s0 = start_cnt;
        n = ins_ack_cnt;
        repeat (10) step();
        checkOutput("full_nostart", 32'(start_cnt - s0), 32'd0);
        checkOutput("full_noack", 32'(ins_ack_cnt - n), 32'd0);

        Pop_Req = 1'b1;
        got_ins = 1'b0; got_pop = 1'b0; pop_first = 1'b0; cyc = 0; k = '0;
        while (!(got_ins && got_pop) && cyc < 100) begin
            step();
            cyc++;
            if (Pop_Ack) begin
                got_pop = 1'b1;
                pop_first = !got_ins;
                k = Pop_Key;
                Pop_Req = 1'b0;
            end
            if (Ins_Ack) begin
                got_ins = 1'b1;
                Ins_Req = 1'b0;
            end
        end
        Ins_Req = 1'b0; Pop_Req = 1'b0;
        step();
        checkOutput("full_both_done", {30'd0, got_ins, got_pop}, 32'd3);
        checkOutput("full_pop_first", {31'd0, pop_first}, 32'd1);
        checkOutput("full_pop_key", 32'(k), 32'd40);
        checkOutput("full_count_64", 32'(Count), 32'd64);

        // Plain flush, then rebuild 12 entries
        Flush = 1'b1; cyc = 0;
        while (!Srt_Start && cyc < 20) begin
            step();
            cyc++;
        end
        checkOutput("flush_start_op", 32'(Srt_Op), 32'd2);
        Flush = 1'b0;
        repeat (4) step();
        checkOutput("flush_count", 32'(Count), 32'd0);
        checkOutput("flush_not_full", {31'd0, Full}, 32'd0);
        for (int i = 0; i < 12; i++)
            do_insert(16'(200 + i), 10'(i), lat);
        checkOutput("count_12", 32'(Count), 32'd12);

        // Flush wins over a pending insert
        Flush = 1'b1; Ins_Req = 1'b1; Ins_Key = 16'd9; Ins_Id = 10'd12;
        ns = 0; cyc = 0;
        while (!Ins_Ack && cyc < 100) begin
            step();
            cyc++;
            if (Srt_Start && ns < 4) begin
                ops[ns] = Srt_Op;
                cnt_at[ns] = Count;
                ns++;
                if (Srt_Op == 2'b10) Flush = 1'b0;
            end
        end
        checkOutput("fi_starts", 32'(ns), 32'd2);
        checkOutput("fi_op0", 32'(ops[0]), 32'd2);
        checkOutput("fi_op1", 32'(ops[1]), 32'd0);
        checkOutput("fi_cnt_clear", 32'(cnt_at[1]), 32'd0);
        checkOutput("fi_count_1", 32'(Count), 32'd1);
        Ins_Req = 1'b0; Flush = 1'b0;
        step();

        do_pop(k, id, e, lat);
        checkOutput("pop_key_9", 32'(k), 32'd9);
        checkOutput("pop_id_12", 32'(id), 32'd12);
        do_pop(k, id, e, lat);
        checkOutput("empty_again", {31'd0, e}, 32'd1);
        checkOutput("popkey_hold", 32'(Pop_Key), 32'd9);

        do_insert(16'd3, 10'd13, lat);
        eng_mute = 1'b1;
`ifdef SORT_SCHED_WDOG_EN
        do_pop(k, id, e, lat);
        checkOutput("wdog_lat", 32'(lat), 32'd257);
        checkOutput("wdog_empty", {31'd0, e}, 32'd1);
        checkOutput("wdog_err", {31'd0, Err}, 32'd1);
        checkOutput("wdog_count", 32'(Count), 32'd1);
`endif
        // Abort mid-WAIT with reset
        Pop_Req = 1'b1;
        n = 0;
        repeat (6) begin
            step();
            if (Pop_Ack) n++;
        end
        checkOutput("stall_noack", 32'(n), 32'd0);
        Reset = 1'b0;
        #1;
        checkOutput("mid_rst_count", 32'(Count), 32'd0);
        checkOutput("mid_rst_outs", {28'd0, Srt_Start, Pop_Ack, Ins_Ack, Err}, 32'd0);
        checkOutput("mid_rst_popkey", 32'(Pop_Key), 32'd0);
        Pop_Req = 1'b0;
        eng_mute = 1'b0;
        step();
        Reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sort_sched.md
# sort_sched

Scheduler that shares the A* open-list sort engine between two requesters: the neighbour-expansion unit, which inserts (f-cost, node id) pairs, and the search controller, which pops the minimum-cost node. It arbitrates round-robin, sequences the engine's start/done handshake, tracks list occupancy, and short-circuits pops on an empty list and inserts on a full list. It sits between the search FSM, the expansion unit and the `sort` engine.

## Interface
- KEY_W, 16, f-cost key width
- ID_W, 10, node id width
- DEPTH, 64, engine capacity in entries
- CNT_W, 7, occupancy counter width; must satisfy 2^CNT_W > DEPTH
- WDOG_CYC, 255, watchdog limit in cycles (only with the macro)

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Ins_Req  in  1  insert request; held high, with key and id stable, until Ins_Ack
- Ins_Key  in  KEY_W  insert key
- Ins_Id  in  ID_W  insert node id
- Ins_Ack  out  1  one-cycle insert completion pulse
- Pop_Req  in  1  pop-min request; held high until Pop_Ack
- Pop_Ack  out  1  one-cycle pop completion pulse
- Pop_Empty  out  1  valid with Pop_Ack; 1 = list was empty and data is invalid
- Pop_Key  out  KEY_W  popped key, registered, valid with Pop_Ack
- Pop_Id  out  ID_W  popped id, registered, valid with Pop_Ack
- Flush  in  1  clear-list request; level, serviced only in IDLE
- Full  out  1  Count == DEPTH
- Count  out  CNT_W  current occupancy
- Srt_Start  out  1  one-cycle engine start pulse
- Srt_Op  out  2  00 insert, 01 pop-min, 10 clear; valid with Srt_Start
- Srt_Key  out  KEY_W  engine key operand
- Srt_Id  out  ID_W  engine id operand
- Srt_Done  in  1  engine completion pulse
- Srt_Key_Out  in  KEY_W  engine popped key, valid with Srt_Done
- Srt_Id_Out  in  ID_W  engine popped id, valid with Srt_Done
- Err  out  1  sticky watchdog error

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, selection priority:
  - Flush has highest priority: go to ISSUE with op 10.
  - Eligible requests: Ins_Req && !Full; Pop_Req.
  - Pop_Req with Count == 0: go directly to RESP with Pop_Empty = 1; no engine access.
  - Both eligible: grant the one not granted last. Pointer resets to favour insert; it updates on every grant, including an empty pop.
  - Insert blocked while Full; it stays pending with no ack.
- ISSUE:
  - Srt_Start = 1.
  - Srt_Op, Srt_Key and Srt_Id come from the granted requester; operands are latched in IDLE and held through WAIT.
  - Next state is WAIT.
- WAIT: stay until Srt_Done = 1, then go to RESP. For a pop, capture Srt_Key_Out and Srt_Id_Out into Pop_Key and Pop_Id.
- RESP:
  - Pulse Ins_Ack or Pop_Ack for the granted requester. Flush has no ack.
  - Update Count: insert +1, non-empty pop −1, clear → 0.
  - Next state is IDLE.
- Count saturates: never exceeds DEPTH and never goes below 0.
- A Srt_Done outside WAIT is ignored.
- Reset values: state IDLE; every output 0, including Count, Err, Pop_Key and Pop_Id.
- Reset mid-operation: the FSM aborts immediately and Count is cleared. The engine must be reset by the same Reset.

## Timing
- All outputs are registered.
- Request high in IDLE at cycle n: Srt_Start at n+1, WAIT from n+2.
- Done sampled at cycle m ≥ n+2: Ack at m+1, IDLE at m+2. Minimum Req-to-Ack latency is 3 cycles.
- Empty pop: Pop_Ack and Pop_Empty at n+1.
- The requester drops Req on the edge where it samples Ack, so it is low by the next IDLE; no duplicate service.
- Pop_Key and Pop_Id hold their value until the next non-empty pop.
- Full and Count change in the RESP cycle and are seen by the IDLE decision that follows.

## Configuration
- SORT_SCHED_WDOG_EN defined:
  - A counter runs in WAIT.
  - If Srt_Done is absent after WDOG_CYC cycles, set Err (sticky until Reset), go to RESP and issue the ack; Pop_Empty = 1 for a pop, and Count is unchanged.
- Not defined: WAIT waits indefinitely; Err is tied to 0.

## Test plan
- Reset, then Pop_Req with an empty list → Pop_Ack with Pop_Empty = 1 one cycle later; Srt_Start is never asserted.
- Insert keys 30, 10, 20 (engine model returns the minimum, Done 2 cycles after Start), then pop → Pop_Key = 10, Count 3→2; Ack is 4 cycles after Req.
- Ins_Req and Pop_Req held together with Count = 5 → grants alternate insert, pop, insert, pop; Count returns to 5.
- Fill to 64 entries, then Ins_Req → no Srt_Start and Full = 1; a pop then lets the insert complete, leaving Count at 64.
- Flush with Count = 12 while Ins_Req is pending → clear op issued first, Count = 0, then the insert proceeds and Count = 1.
- With SORT_SCHED_WDOG_EN: engine never returns Done on a pop → after 255 WAIT cycles Err = 1 and Pop_Ack with Pop_Empty = 1; Assert Reset mid-WAIT → all outputs 0.
